// File: rtl/acq_pkg.sv
// Shared types for the acquisition channel: FSM encoding and bus sample packing.
// No logic here; latency and backpressure are properties of the users.
// Imported by acq_ram and acq_buf.
`timescale 1ns/1ps
package acq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_ARM  = 2'd2,
        ST_POST = 2'd3
    } acq_st_t;

    localparam int SMP_PER_WORD = 2;
    localparam int SMP_SEL_W    = $clog2(SMP_PER_WORD);

endpackage

// File: rtl/acq_ram.sv
// Sample buffer split into even/odd banks: one sample write, one dual-sample read.
// Latency: read data registered, 1 cycle after rd_vld; same-cycle write returns old data.
// Backpressure: none, both ports accept every cycle.
`timescale 1ns/1ps
module acq_ram
    import acq_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_vld,
    input  logic [AW-1:0]           wr_addr,
    input  logic [DW-1:0]           wr_dat,
    input  logic                    rd_vld,
    input  logic [AW-SMP_SEL_W-1:0] rd_addr,
    output logic [DW-1:0]           rd_lo_dat,
    output logic [DW-1:0]           rd_hi_dat
);

    localparam int BD = 2 ** (AW - SMP_SEL_W);

    logic [DW-1:0] bank_lo [BD];
    logic [DW-1:0] bank_hi [BD];
    logic [DW-1:0] rd_lo_q;
    logic [DW-1:0] rd_hi_q;

    always_ff @(posedge clk) begin
        if (wr_vld && !wr_addr[0]) begin
            bank_lo[wr_addr[AW-1:SMP_SEL_W]] <= wr_dat;
        end
        if (wr_vld && wr_addr[0]) begin
            bank_hi[wr_addr[AW-1:SMP_SEL_W]] <= wr_dat;
        end
    end

    // Output register only is reset so the bus reads 0 during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_lo_q <= '0;
            rd_hi_q <= '0;
        end else if (rd_vld) begin
            rd_lo_q <= bank_lo[rd_addr];
            rd_hi_q <= bank_hi[rd_addr];
        end
    end

    assign rd_lo_dat = rd_lo_q;
    assign rd_hi_dat = rd_hi_q;

endmodule

// File: rtl/acq_buf.sv
// Stream-to-circular-buffer capture with pre/post trigger FSM; ACQ_LAST_STOP_EN lets tlast end POST early.
// Latency: beat written the cycle it is accepted; irq_* combinational in the event cycle, trg_o one cycle later; bus reads 1 cycle.
// Backpressure: never; sti_tready is high whenever rst is low.
`timescale 1ns/1ps
module acq_buf
    import acq_pkg::*;
#(
    parameter int DW  = 16,
    parameter int AW  = 14,
    parameter int TN  = 1,
    parameter int CWL = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  sti_tdata,
    input  logic           sti_tvalid,
    input  logic           sti_tlast,
    output logic           sti_tready,
    input  logic           ctl_rst,
    input  logic           ctl_acq,
    input  logic [TN-1:0]  trg_i,
    output logic           trg_o,
    output logic           irq_trg,
    output logic           irq_stp,
    input  logic [TN-1:0]  cfg_trg,
    input  logic [CWL-1:0] cfg_pre,
    input  logic [CWL-1:0] cfg_pst,
    output logic           sts_run,
    output logic [AW-1:0]  sts_ptr,
    output logic [CWL-1:0] sts_cnt,
    input  logic           bus_wen,
    input  logic           bus_ren,
    input  logic [31:0]    bus_addr,
    input  logic [31:0]    bus_wdata,
    output logic [31:0]    bus_rdata,
    output logic           bus_ack,
    output logic           bus_err
);

    acq_st_t        state_q, state_d;
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  ptr_q, ptr_d;
    logic [CWL-1:0] cnt_q, cnt_d;
    logic           trg_q, trg_d;
    logic           ack_q, ack_d;

    logic           acc;
    logic           trig;
    logic           last_stop;
    logic           wr_vld;
    logic [CWL-1:0] cnt_inc;
    logic [CWL:0]   pst_end;
    logic [DW-1:0]  rd_lo_dat, rd_hi_dat;
    logic [15:0]    rd_lo16, rd_hi16;
    logic           unused_bits;

    assign sti_tready = ~rst;
    assign acc        = sti_tvalid & sti_tready;
    assign trig       = |(trg_i & cfg_trg);
    assign cnt_inc    = cnt_q + CWL'(1);
    assign pst_end    = {1'b0, cfg_pst} + (CWL+1)'(1);

`ifdef ACQ_LAST_STOP_EN
    assign last_stop = acc & sti_tlast;
`else
    assign last_stop = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        trg_d   = 1'b0;
        wr_vld  = 1'b0;
        irq_trg = 1'b0;
        irq_stp = 1'b0;
        if (ctl_rst) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctl_acq) begin
                        state_d = ST_PRE;
                        cnt_d   = '0;
                    end
                end
                ST_PRE: begin
                    wr_vld = acc;
                    if (cnt_q == cfg_pre) begin
                        state_d = ST_ARM;
                    end else if (acc) begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_ARM: begin
                    wr_vld = acc;
                    if (trig) begin
                        state_d = ST_POST;
                        ptr_d   = wptr_q;
                        irq_trg = 1'b1;
                        trg_d   = 1'b1;
                        cnt_d   = acc ? CWL'(1) : '0;
                        // A beat in the trigger cycle may already complete a 1-beat post window.
                        if (acc && pst_end == (CWL+1)'(1)) begin
                            state_d = ST_IDLE;
                            irq_stp = 1'b1;
                        end
                    end
                end
                ST_POST: begin
                    wr_vld = acc;
                    if (acc) begin
                        cnt_d = cnt_inc;
                        if ({1'b0, cnt_inc} == pst_end || last_stop) begin
                            state_d = ST_IDLE;
                            irq_stp = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        wptr_d = wr_vld ? wptr_q + AW'(1) : wptr_q;
        ack_d  = bus_ren | bus_wen;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            trg_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            trg_q   <= trg_d;
            ack_q   <= ack_d;
        end
    end

    acq_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_vld    (wr_vld),
        .wr_addr   (wptr_q),
        .wr_dat    (sti_tdata),
        .rd_vld    (bus_ren),
        .rd_addr   (bus_addr[2 +: AW-SMP_SEL_W]),
        .rd_lo_dat (rd_lo_dat),
        .rd_hi_dat (rd_hi_dat)
    );

    always_comb begin
        rd_lo16         = '0;
        rd_hi16         = '0;
        rd_lo16[DW-1:0] = rd_lo_dat;
        rd_hi16[DW-1:0] = rd_hi_dat;
    end

    assign bus_rdata   = {rd_hi16, rd_lo16};
    assign bus_ack     = ack_q;
    assign bus_err     = 1'b0;
    assign trg_o       = trg_q;
    assign sts_run     = (state_q != ST_IDLE);
    assign sts_ptr     = ptr_q;
    assign sts_cnt     = cnt_q;
    assign unused_bits = ^{bus_wdata, bus_addr, sti_tlast};

endmodule

// File: tb/tb_acq_buf.sv
// Self-checking bench for acq_buf (AW=4 to exercise wrap, TN=2 to exercise masking).
`timescale 1ns/1ps
module tb_acq_buf;

    localparam int DW = 16, AW = 4, TN = 2, CWL = 32;
    localparam int DEPTH = 2 ** AW;

    logic           clk = 1'b0;
    logic           rst;
    logic [DW-1:0]  sti_tdata;
    logic           sti_tvalid, sti_tlast, sti_tready;
    logic           ctl_rst, ctl_acq;
    logic [TN-1:0]  trg_i, cfg_trg;
    logic           trg_o, irq_trg, irq_stp;
    logic [CWL-1:0] cfg_pre, cfg_pst, sts_cnt;
    logic           sts_run;
    logic [AW-1:0]  sts_ptr;
    logic           bus_wen, bus_ren, bus_ack, bus_err;
    logic [31:0]    bus_addr, bus_wdata, bus_rdata;

    acq_buf #(.DW(DW), .AW(AW), .TN(TN), .CWL(CWL)) dut (
        .clk(clk), .rst(rst),
        .sti_tdata(sti_tdata), .sti_tvalid(sti_tvalid), .sti_tlast(sti_tlast), .sti_tready(sti_tready),
        .ctl_rst(ctl_rst), .ctl_acq(ctl_acq),
        .trg_i(trg_i), .trg_o(trg_o), .irq_trg(irq_trg), .irq_stp(irq_stp),
        .cfg_trg(cfg_trg), .cfg_pre(cfg_pre), .cfg_pst(cfg_pst),
        .sts_run(sts_run), .sts_ptr(sts_ptr), .sts_cnt(sts_cnt),
        .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_mem [DEPTH];
    int          wp;
    logic [31:0] exp_q [$];
    logic        s_irq_trg, s_irq_stp, s_trg_o;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given stream/trigger inputs; outputs captured at negedge.
    task automatic step(input logic v, input logic [15:0] d, input logic [1:0] t, input logic last);
        sti_tvalid = v;
        sti_tdata  = d;
        trg_i      = t;
        sti_tlast  = last;
        @(negedge clk);
        s_irq_trg = irq_trg;
        s_irq_stp = irq_stp;
        s_trg_o   = trg_o;
        @(posedge clk);
        #1;
        sti_tvalid = 1'b0;
        trg_i      = '0;
        sti_tlast  = 1'b0;
        ctl_acq    = 1'b0;
        ctl_rst    = 1'b0;
        bus_ren    = 1'b0;
        bus_wen    = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d, input logic [1:0] t, input logic last, input logic wr);
        if (wr) begin
            exp_mem[wp] = d;
            wp = (wp + 1) % DEPTH;
        end
        step(1'b1, d, t, last);
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 2'b00, 1'b0);
    endtask

    task automatic bus_rd(input int w);
        exp_q.push_back({exp_mem[(2*w+1) % DEPTH], exp_mem[(2*w) % DEPTH]});
        bus_ren  = 1'b1;
        bus_addr = 32'(w * 4);
        idle();
        idle();
    endtask

    always @(negedge clk) begin
        if (!rst && bus_ack && exp_q.size() > 0) begin
            chk("bus_rd", bus_rdata, exp_q.pop_front());
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int trg_at, stp_at, trgo_at, nirq, exp_ptr, exp_stp;
        rst = 1'b1;
        sti_tdata = '0; sti_tvalid = 1'b0; sti_tlast = 1'b0;
        ctl_rst = 1'b0; ctl_acq = 1'b0; trg_i = '0; cfg_trg = 2'b01;
        cfg_pre = '0; cfg_pst = '0;
        bus_wen = 1'b0; bus_ren = 1'b0; bus_addr = '0; bus_wdata = 32'hFFFF_FFFF;
        wp = 0;
        repeat (3) @(negedge clk);
        chk("rst_tready", 32'(sti_tready), 0);
        chk("rst_run", 32'(sts_run), 0);
        chk("rst_ptr", 32'(sts_ptr), 0);
        chk("rst_cnt", sts_cnt, 0);
        chk("rst_outs", {26'd0, bus_ack, bus_err, irq_trg, irq_stp, trg_o, 1'b0}, 0);
        chk("rst_rdata", bus_rdata, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("tready_up", 32'(sti_tready), 1);
        @(posedge clk); #1;

        // Basic capture: pre 4, post 8, trigger on the 10th beat.
        cfg_pre = 4; cfg_pst = 7;
        trg_at = -1; stp_at = -1; trgo_at = -1;
        ctl_acq = 1'b1; idle();
        for (int i = 0; i < 17; i++) begin
            beat(16'(i), (i == 9) ? 2'b01 : 2'b00, 1'b0, 1'b1);
            if (s_irq_trg) trg_at = i;
            if (s_irq_stp) stp_at = i;
            if (s_trg_o && trgo_at < 0) trgo_at = i;
            if (i == 3) chk("A_pre_cnt", sts_cnt, 4);
        end
        chk("A_trg_at", 32'(trg_at), 9);
        chk("A_stp_at", 32'(stp_at), 16);
        chk("A_trgo_at", 32'(trgo_at), 10);
        chk("A_ptr", 32'(sts_ptr), 9);
        chk("A_cnt", sts_cnt, 8);
        chk("A_run", 32'(sts_run), 0);
        beat(16'h00AA, 2'b00, 1'b0, 1'b0);
        bus_rd(4);
        bus_rd(0);

        // cfg_pre=0; trigger without a beat; first post beat lands at sts_ptr.
        cfg_pre = 0; cfg_pst = 3; stp_at = -1;
        ctl_acq = 1'b1; idle();
        idle();
        chk("B_run", 32'(sts_run), 1);
        exp_ptr = wp;
        step(1'b0, 16'h0, 2'b01, 1'b0);
        chk("B_irq_trg", 32'(s_irq_trg), 1);
        chk("B_cnt0", sts_cnt, 0);
        chk("B_ptr", 32'(sts_ptr), 32'(exp_ptr));
        for (int i = 0; i < 4; i++) begin
            beat(16'(16'h0100 + i), 2'b00, 1'b0, 1'b1);
            if (s_irq_stp) stp_at = i;
        end
        chk("B_stp_at", 32'(stp_at), 3);
        chk("B_first_at_ptr", 32'(exp_mem[exp_ptr]), 32'h0100);
        bus_rd(0);
        bus_rd(1);
        bus_rd(2);

        // Triggers held through PRE (including its last cycle) and a masked trigger are ignored.
        cfg_pre = 100; cfg_pst = 0; nirq = 0;
        ctl_acq = 1'b1; idle();
        for (int i = 0; i <= 100; i++) begin
            beat(16'(16'h0200 + i), 2'b01, 1'b0, 1'b1);
            nirq += int'(s_irq_trg);
        end
        chk("C_pre_ign", 32'(nirq), 0);
        chk("C_run", 32'(sts_run), 1);
        beat(16'h0265, 2'b00, 1'b0, 1'b1);
        nirq += int'(s_irq_trg);
        beat(16'h0266, 2'b10, 1'b0, 1'b1);
        nirq += int'(s_irq_trg);
        chk("C_mask", 32'(nirq), 0);
        exp_ptr = wp;
        beat(16'h0267, 2'b01, 1'b0, 1'b1);
        chk("C_irq_pair", {30'd0, s_irq_trg, s_irq_stp}, 32'h3);
        chk("C_ptr", 32'(sts_ptr), 32'(exp_ptr));
        chk("C_run_end", 32'(sts_run), 0);
        idle();
        chk("C_trg_o", 32'(s_trg_o), 1);
        bus_rd(exp_ptr / 2);

        // ctl_rst in POST: no stop irq, beat dropped, pointer kept.
        cfg_pre = 0; cfg_pst = 7;
        ctl_acq = 1'b1; idle();
        idle();
        exp_ptr = wp;
        step(1'b0, 16'h0, 2'b01, 1'b0);
        for (int i = 0; i < 3; i++) beat(16'(16'h0300 + i), 2'b00, 1'b0, 1'b1);
        chk("E_cnt3", sts_cnt, 3);
        ctl_rst = 1'b1;
        beat(16'hDEAD, 2'b00, 1'b0, 1'b0);
        chk("E_no_stp", 32'(s_irq_stp), 0);
        chk("E_run", 32'(sts_run), 0);
        chk("E_cnt", sts_cnt, 0);
        chk("E_ptr", 32'(sts_ptr), 32'(exp_ptr));
        bus_rd(wp / 2);

        // Async reset mid-POST clears outputs without waiting for an edge.
        ctl_acq = 1'b1; idle();
        idle();
        step(1'b0, 16'h0, 2'b01, 1'b0);
        beat(16'h0400, 2'b00, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("R_run", 32'(sts_run), 0);
        chk("R_ptr_cnt", {28'd0, sts_ptr} | sts_cnt, 0);
        chk("R_tready", 32'(sti_tready), 0);
        @(posedge clk); #1; rst = 1'b0;
        wp = 0;

        // 20 beats before trigger with a 16-deep buffer: pointer wraps to 4.
        cfg_pre = 0; cfg_pst = 1; stp_at = -1;
        ctl_acq = 1'b1; idle();
        for (int i = 0; i < 20; i++) beat(16'(16'h0500 + i), 2'b00, 1'b0, 1'b1);
        step(1'b0, 16'h0, 2'b01, 1'b0);
        chk("D_ptr", 32'(sts_ptr), 4);
        for (int i = 0; i < 2; i++) begin
            beat(16'(16'h0600 + i), 2'b00, 1'b0, 1'b1);
            if (s_irq_stp) stp_at = i;
        end
        chk("D_stp_at", 32'(stp_at), 1);
        bus_rd(0);
        bus_rd(1);
        bus_rd(2);

        // Bus write is acknowledged and leaves the buffer alone.
        bus_wen = 1'b1; bus_addr = 32'h0;
        idle();
        chk("W_ack", 32'(bus_ack), 1);
        idle();
        bus_rd(0);

        // tlast on the 5th post beat with a long post window.
        cfg_pre = 0; cfg_pst = 1000; stp_at = -1;
        ctl_acq = 1'b1; idle();
        idle();
        step(1'b0, 16'h0, 2'b01, 1'b0);
        for (int i = 0; i < 1100 && stp_at < 0; i++) begin
            beat(16'(16'h0700 + i), 2'b00, (i == 4), 1'b1);
            if (s_irq_stp) stp_at = i;
        end
`ifdef ACQ_LAST_STOP_EN
        exp_stp = 4;
`else
        exp_stp = 1000;
`endif
        chk("F_stp_at", 32'(stp_at), 32'(exp_stp));
        chk("F_cnt", sts_cnt, 32'(exp_stp + 1));
        chk("F_run", 32'(sts_run), 0);
        bus_rd(((wp + DEPTH - 1) % DEPTH) / 2);

        idle();
        chk("sb_drain", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
